// File: rtl/quantum_pkg.sv
// quantum_pkg: shared state type and default widths for the quantum timer.
package quantum_pkg;

   localparam int unsigned QNT_W   = 16;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned MIN_QNT = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PEND    = 2'd2,
      ST_SERVICE = 2'd3
   } qnt_state_t;

endpackage

// File: rtl/qnt_counter.sv
// qnt_counter: loadable down-counter; loads are clamped up to MIN_QNT.
// Priority: load, then hold, then dec. zero_next flags a 1->0 step on this edge.
module qnt_counter #(
   parameter int unsigned QNT_W   = 16,
   parameter int unsigned MIN_QNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [QNT_W-1:0] value,
   input  logic             dec,
   input  logic             hold,
   output logic [QNT_W-1:0] count,
   output logic             zero_next
);

   localparam logic [QNT_W-1:0] MinVal = QNT_W'(MIN_QNT);
   localparam logic [QNT_W-1:0] One    = QNT_W'(1);

   logic [QNT_W-1:0] count_q, count_d, load_val;
   logic             do_dec;

   // Unsigned clamp of the requested quantum.
   always_comb begin
      load_val = (value < MinVal) ? MinVal : value;
   end

   // Decrement only when asked, not held, and not already at zero.
   always_comb begin
      do_dec  = dec && !hold && !load && (count_q != '0);
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (do_dec) begin
         count_d = count_q - One;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count     = count_q;
   assign zero_next = do_dec && (count_q == One);

endmodule

// File: rtl/quantum_timer_ctrl.sv
// quantum_timer_ctrl: preemption scheduler. Counts down a time quantum, requests an
// interrupt on expiry, captures the return PC on acceptance and freezes while the
// handler runs. Define QNT_HALT_PAUSE_EN to freeze the quantum while the core is halted.
module quantum_timer_ctrl
   import quantum_pkg::*;
#(
   parameter int unsigned QNT_W   = quantum_pkg::QNT_W,
   parameter int unsigned PC_W    = quantum_pkg::PC_W,
   parameter int unsigned MIN_QNT = quantum_pkg::MIN_QNT,
   parameter int unsigned CNT_W   = quantum_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             qnt_load,
   input  logic [QNT_W-1:0] qnt_value,
   input  logic             halt,
   input  logic             int_ack,
   input  logic [PC_W-1:0]  pc_in,
   output logic             int_sig,
   output logic [PC_W-1:0]  epc,
   output logic [QNT_W-1:0] qnt_count,
   output logic             in_service,
   output logic [CNT_W-1:0] preempt_cnt
);

   qnt_state_t       state_q, state_d;
   logic             enable_q;
   logic [PC_W-1:0]  epc_q;
   logic [CNT_W-1:0] pcnt_q;
   logic             run_active, cnt_load, cnt_dec, cnt_hold, zero_next, accept;
   logic [QNT_W-1:0] count;

   assign run_active = (state_q == ST_RUN) && enable;

`ifdef QNT_HALT_PAUSE_EN
   assign cnt_dec = run_active && !halt;
`else
   assign cnt_dec = run_active;
`endif
   assign cnt_hold = !cnt_dec;

   // A disable in PEND drops the request, so acceptance needs enable too.
   assign accept = (state_q == ST_PEND) && enable && int_ack;

   qnt_counter #(
      .QNT_W   (QNT_W),
      .MIN_QNT (MIN_QNT)
   ) u_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (cnt_load),
      .value     (qnt_value),
      .dec       (cnt_dec),
      .hold      (cnt_hold),
      .count     (count),
      .zero_next (zero_next)
   );

   // Next-state and counter-load decode.
   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_load = qnt_load;
            if (qnt_load && enable) begin
               state_d = ST_RUN;
            end else if (enable && !enable_q && (count != '0)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (qnt_load) begin
               cnt_load = 1'b1;
            end else if (zero_next) begin
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (int_ack) begin
               state_d = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            // Handler reprogramming the quantum ends service.
            if (qnt_load) begin
               cnt_load = 1'b1;
               state_d  = enable ? ST_RUN : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, enable history, return PC and preemption count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         enable_q <= 1'b0;
         epc_q    <= '0;
         pcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         enable_q <= enable;
         if (accept) begin
            epc_q  <= pc_in;
            pcnt_q <= pcnt_q + CNT_W'(1);
         end
      end
   end

   assign int_sig     = (state_q == ST_PEND);
   assign in_service  = (state_q == ST_SERVICE);
   assign qnt_count   = count;
   assign epc         = epc_q;
   assign preempt_cnt = pcnt_q;

endmodule

// File: tb/tb_quantum_timer_ctrl.sv
// Bench for quantum_timer_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_quantum_timer_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        qnt_load = 1'b0;
   logic [15:0] qnt_value = '0;
   logic        halt = 1'b0;
   logic        int_ack = 1'b0;
   logic [31:0] pc_in = '0;
   logic        int_sig;
   logic [31:0] epc;
   logic [15:0] qnt_count;
   logic        in_service;
   logic [7:0]  preempt_cnt;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   localparam int M_IDLE = 0, M_RUN = 1, M_PEND = 2, M_SERVICE = 3;
   localparam int MINQ = 4;

   // Behavioural model state.
   int          m_mode = M_IDLE;
   int          m_cnt  = 0;
   logic [31:0] m_epc  = '0;
   int          m_np   = 0;
   bit          m_en_prev = 1'b0;

   quantum_timer_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .qnt_load    (qnt_load),
      .qnt_value   (qnt_value),
      .halt        (halt),
      .int_ack     (int_ack),
      .pc_in       (pc_in),
      .int_sig     (int_sig),
      .epc         (epc),
      .qnt_count   (qnt_count),
      .in_service  (in_service),
      .preempt_cnt (preempt_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp(input int v);
      return (v < MINQ) ? MINQ : v;
   endfunction

   // Model: apply the scheduler rules once per clock edge.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_mode = M_IDLE; m_cnt = 0; m_epc = '0; m_np = 0; m_en_prev = 1'b0;
      end else begin
         bit rising;
         bit paused;
         rising    = enable && !m_en_prev;
         m_en_prev = enable;
`ifdef QNT_HALT_PAUSE_EN
         paused = halt;
`else
         paused = 1'b0;
`endif
         case (m_mode)
            M_IDLE: begin
               if (qnt_load) begin
                  m_cnt = clamp(int'(qnt_value));
                  if (enable) m_mode = M_RUN;
               end else if (rising && m_cnt != 0) begin
                  m_mode = M_RUN;
               end
            end
            M_RUN: begin
               if (!enable) m_mode = M_IDLE;
               else if (qnt_load) m_cnt = clamp(int'(qnt_value));
               else if (!paused && m_cnt > 0) begin
                  m_cnt--;
                  if (m_cnt == 0) m_mode = M_PEND;
               end
            end
            M_PEND: begin
               if (!enable) m_mode = M_IDLE;
               else if (int_ack) begin
                  m_epc  = pc_in;
                  m_np   = (m_np + 1) % 256;
                  m_mode = M_SERVICE;
               end
            end
            default: begin
               if (qnt_load) begin
                  m_cnt  = clamp(int'(qnt_value));
                  m_mode = enable ? M_RUN : M_IDLE;
               end
            end
         endcase
      end
   end

   // Per-cycle comparison against the model, just after each active edge.
   initial forever begin
      @(posedge clk);
      #1;
      if (chk_on) begin
         check("m_int_sig", int_sig, m_mode == M_PEND);
         check("m_in_service", in_service, m_mode == M_SERVICE);
         check("m_qnt_count", qnt_count, m_cnt);
         check("m_epc", epc, m_epc);
         check("m_preempt_cnt", preempt_cnt, m_np);
      end
   end

   task automatic step(input logic en, input logic ld, input int val, input logic hl,
                       input logic ak, input logic [31:0] pc);
      enable = en; qnt_load = ld; qnt_value = val[15:0]; halt = hl; int_ack = ak; pc_in = pc;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      int exp_edge;
      repeat (2) @(negedge clk);
      check("reset_int_sig", int_sig, 0);
      check("reset_epc", epc, 0);
      check("reset_qnt_count", qnt_count, 0);
      check("reset_in_service", in_service, 0);
      check("reset_preempt_cnt", preempt_cnt, 0);
      rst_n = 1'b1;
      chk_on = 1'b1;

      // Load 5 and expire.
      step(1'b1, 1'b1, 5, 1'b0, 1'b0, 32'h0);
      check("load5_count", qnt_count, 5);
      for (int i = 1; i <= 4; i++) begin
         idle(1);
         check("load5_no_int", int_sig, 0);
      end
      check("load5_count1", qnt_count, 1);
      idle(1);
      check("load5_int_edge5", int_sig, 1);
      check("load5_count0", qnt_count, 0);
      idle(2);
      check("load5_int_held", int_sig, 1);
      step(1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h40);
      check("ack_epc", epc, 32'h40);
      check("ack_pcnt", preempt_cnt, 1);
      check("ack_in_service", in_service, 1);
      check("ack_int_low", int_sig, 0);

      // Stray acks in SERVICE and RUN, then an 8-cycle quantum.
      step(1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h99);
      check("svc_ack_epc", epc, 32'h40);
      check("svc_ack_pcnt", preempt_cnt, 1);
      step(1'b1, 1'b1, 8, 1'b0, 1'b0, 32'h0);
      check("svc_load_count", qnt_count, 8);
      check("svc_load_exit", in_service, 0);
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, 0, 1'b0, i == 1, 32'h77);
         if (i == 1) check("run_ack_epc", epc, 32'h40);
         check("q8_int", int_sig, i == 8);
      end
      step(1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h80);
      check("ack2_epc", epc, 32'h80);
      check("ack2_pcnt", preempt_cnt, 2);

      // Clamp: 0 and 2 both load MIN_QNT.
      step(1'b1, 1'b1, 0, 1'b0, 1'b0, 32'h0);
      check("clamp0", qnt_count, 4);
      step(1'b1, 1'b1, 2, 1'b0, 1'b0, 32'h0);
      check("clamp2", qnt_count, 4);
      for (int i = 1; i <= 4; i++) begin
         idle(1);
         check("clamp_expiry", int_sig, i == 4);
      end
      step(1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h100);

      // Reload on the expiry edge wins.
      step(1'b1, 1'b1, 5, 1'b0, 1'b0, 32'h0);
      idle(4);
      check("pre_expiry_count", qnt_count, 1);
      step(1'b1, 1'b1, 10, 1'b0, 1'b0, 32'h0);
      check("reload_count", qnt_count, 10);
      check("reload_no_pend", int_sig, 0);
      for (int i = 1; i <= 10; i++) begin
         idle(1);
         check("reload_expiry", int_sig, i == 10);
      end
      step(1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h104);

      // Halt for three cycles mid-run.
`ifdef QNT_HALT_PAUSE_EN
      exp_edge = 9;
`else
      exp_edge = 6;
`endif
      step(1'b1, 1'b1, 6, 1'b0, 1'b0, 32'h0);
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 1'b0, 0, (i >= 2 && i <= 4), 1'b0, 32'h0);
         check("halt_expiry", int_sig, i >= exp_edge);
      end
      step(1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h108);
      check("ack5_pcnt", preempt_cnt, 5);

      // Disable in PEND drops the request.
      step(1'b1, 1'b1, 4, 1'b0, 1'b0, 32'h0);
      idle(4);
      check("dis_pend", int_sig, 1);
      step(1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
      check("dis_int_low", int_sig, 0);
      check("dis_count", qnt_count, 0);
      idle(3);
      check("dis_stay_idle", int_sig, 0);
      step(1'b0, 1'b1, 7, 1'b0, 1'b0, 32'h0);
      check("idle_load_off", qnt_count, 7);
      step(1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
      check("idle_hold", qnt_count, 7);
      idle(1);
      check("enable_rise", qnt_count, 7);
      idle(2);
      check("enable_run", qnt_count, 5);

      // Asynchronous reset mid-run.
      #2 rst_n = 1'b0;
      #1;
      check("areset_count", qnt_count, 0);
      check("areset_epc", epc, 0);
      check("areset_pcnt", preempt_cnt, 0);
      check("areset_int", int_sig, 0);
      check("areset_svc", in_service, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic en, ld, hl, ak;
         int   v;
         en = ($urandom_range(0, 99) < 96);
         ld = ($urandom_range(0, 99) < 6);
         v  = $urandom_range(0, 24);
         hl = ($urandom_range(0, 2) == 0);
         ak = ($urandom_range(0, 3) == 0);
         if (!en && (m_mode == M_RUN || m_mode == M_PEND)) begin
            ld = 1'b0;
            ak = 1'b0;
         end
         step(en, ld, v, hl, ak, $urandom());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
